// File: rtl/ifetch_pkg.sv
// Shared types and widths for the instruction fetch front-end.
`default_nettype none

package ifetch_pkg;

    localparam int INDEX_W = 32;
    localparam int DATA_W  = 16;
    localparam int ENTRY_W = DATA_W + INDEX_W;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [INDEX_W-1:0] index;
    } entry_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_fifo.sv
// Synchronous prefetch FIFO; flush wins over push and pop.
`default_nettype none

module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = ENTRY_W,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             not_reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_eff;
    logic             pop_eff;

    assign pop_eff  = pop & (count_q != '0);
    assign push_eff = push & ((count_q != CNT_W'(DEPTH)) | pop_eff);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by plain overflow.
            if (push_eff) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_eff)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_eff, pop_eff})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_eff && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: icache requester, prefetch FIFO and redirect handling.
`default_nettype none

module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int unsigned        DEPTH       = 4,
    parameter logic [INDEX_W-1:0] RESET_INDEX = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               not_reset,
    output logic               icache_not_enable,
    output logic [INDEX_W-1:0] icache_index,
    input  logic [DATA_W-1:0]  icache_data,
    output logic [DATA_W-1:0]  instr,
    output logic [INDEX_W-1:0] instr_index,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [INDEX_W-1:0] redirect_index
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    state_e             state_q, state_d;
    logic [INDEX_W-1:0] fetch_index_q, fetch_index_d;
    logic [INDEX_W-1:0] pend_index_q, pend_index_d;
    logic               pending_q, pending_d;

    logic [CNT_W-1:0]   count;
    logic [OCC_W-1:0]   occupancy;
    logic               credit;
    logic               issue;
    logic               push;
    logic               pop;
    entry_t             din;
    entry_t             dout;

    // Same-cycle pops are not credited, so occupancy may briefly overstate.
    assign occupancy = OCC_W'(count) + OCC_W'(pending_q);
    assign credit    = occupancy < OCC_W'(DEPTH);
    assign issue     = (state_q == RUN) & ~redirect & credit;

    assign icache_not_enable = ~issue;
    assign icache_index      = fetch_index_q;

    assign push       = pending_q & ~redirect;
    assign pop        = instr_valid & instr_ready;
    assign din.data   = icache_data;
    assign din.index  = pend_index_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (!credit) state_d = HOLD;
            HOLD:    if (credit)  state_d = RUN;
            default: state_d = BOOT;
        endcase
        if (redirect) state_d = RUN;
    end

    always_comb begin
        fetch_index_d = fetch_index_q;
        pend_index_d  = pend_index_q;
        pending_d     = issue;
        if (redirect) begin
            fetch_index_d = redirect_index;
        end else if (issue) begin
            fetch_index_d = fetch_index_q + INDEX_W'(1);
            pend_index_d  = fetch_index_q;
        end
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state_q       <= BOOT;
            fetch_index_q <= RESET_INDEX;
            pend_index_q  <= '0;
            pending_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_index_q <= fetch_index_d;
            pend_index_q  <= pend_index_d;
            pending_q     <= pending_d;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock     (clock),
        .not_reset (not_reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect),
        .din       (din),
        .dout      (dout),
        .count     (count)
    );

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? dout.data  : '0;
    assign instr_index = instr_valid ? dout.index : '0;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// Directed vector bench for ifetch_unit with a one-cycle-latency icache model.
`default_nettype none

module tb_ifetch_unit;

    logic        clock;
    logic        not_reset;
    logic        icache_not_enable;
    logic [31:0] icache_index;
    logic [15:0] icache_data;
    logic [15:0] instr;
    logic [31:0] instr_index;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_index;

    int checks = 0;
    int errors = 0;

    ifetch_unit #(
        .DEPTH       (4),
        .RESET_INDEX (32'h0000_0000)
    ) dut (
        .clock             (clock),
        .not_reset         (not_reset),
        .icache_not_enable (icache_not_enable),
        .icache_index      (icache_index),
        .icache_data       (icache_data),
        .instr             (instr),
        .instr_index       (instr_index),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .redirect          (redirect),
        .redirect_index    (redirect_index)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // icache model: mem[i] = 16'hA000 + i, data appears the cycle after the request edge.
    always @(posedge clock) begin
        if (!icache_not_enable) icache_data <= 16'hA000 + icache_index[15:0];
    end

    typedef struct {
        logic        rst;
        logic        ready;
        logic        redir;
        logic [31:0] ridx;
        logic        nen;
        logic [31:0] idx;
        logic        valid;
        logic [15:0] ins;
        logic [31:0] iidx;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic ready, input logic redir,
                       input logic [31:0] ridx, input logic nen, input logic [31:0] idx,
                       input logic valid, input logic [15:0] ins, input logic [31:0] iidx);
        vec_t t;
        t.rst = rst; t.ready = ready; t.redir = redir; t.ridx = ridx;
        t.nen = nen; t.idx = idx; t.valid = valid; t.ins = ins; t.iidx = iidx;
        vecs.push_back(t);
    endtask

    task automatic add_rst(input logic ready);
        add(1, ready, 0, 0, 1, 32'h0, 0, 16'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] exp_next;
        int          pops;

        not_reset      = 1'b0;
        instr_ready    = 1'b0;
        redirect       = 1'b0;
        redirect_index = 32'h0;
        icache_data    = 16'h0;

        // A: boot and steady streaming with decode always ready.
        add_rst(1);
        add(0, 1, 0, 0, 1, 32'h0, 0, 16'h0,    32'h0);
        add(0, 1, 0, 0, 0, 32'h0, 0, 16'h0,    32'h0);
        add(0, 1, 0, 0, 0, 32'h1, 0, 16'h0,    32'h0);
        add(0, 1, 0, 0, 0, 32'h2, 1, 16'hA000, 32'h0);
        add(0, 1, 0, 0, 0, 32'h3, 1, 16'hA001, 32'h1);
        add(0, 1, 0, 0, 0, 32'h4, 1, 16'hA002, 32'h2);
        // B: decode stalled fills FIFO to DEPTH, then drains and resumes at 4.
        add_rst(0);
        add(0, 0, 0, 0, 1, 32'h0, 0, 16'h0,    32'h0);
        add(0, 0, 0, 0, 0, 32'h0, 0, 16'h0,    32'h0);
        add(0, 0, 0, 0, 0, 32'h1, 0, 16'h0,    32'h0);
        add(0, 0, 0, 0, 0, 32'h2, 1, 16'hA000, 32'h0);
        add(0, 0, 0, 0, 0, 32'h3, 1, 16'hA000, 32'h0);
        add(0, 0, 0, 0, 1, 32'h4, 1, 16'hA000, 32'h0);
        add(0, 0, 0, 0, 1, 32'h4, 1, 16'hA000, 32'h0);
        add(0, 1, 0, 0, 1, 32'h4, 1, 16'hA000, 32'h0);
        add(0, 1, 0, 0, 1, 32'h4, 1, 16'hA001, 32'h1);
        add(0, 1, 0, 0, 0, 32'h4, 1, 16'hA002, 32'h2);
        add(0, 1, 0, 0, 0, 32'h5, 1, 16'hA003, 32'h3);
        add(0, 1, 0, 0, 0, 32'h6, 1, 16'hA004, 32'h4);
        // C: redirect to 0x100 with three queued entries and one pending.
        add_rst(0);
        add(0, 0, 0, 0, 1, 32'h0, 0, 16'h0,    32'h0);
        add(0, 0, 0, 0, 0, 32'h0, 0, 16'h0,    32'h0);
        add(0, 0, 0, 0, 0, 32'h1, 0, 16'h0,    32'h0);
        add(0, 0, 0, 0, 0, 32'h2, 1, 16'hA000, 32'h0);
        add(0, 0, 0, 0, 0, 32'h3, 1, 16'hA000, 32'h0);
        add(0, 0, 1, 32'h100, 1, 32'h4, 1, 16'hA000, 32'h0);
        add(0, 0, 0, 0, 0, 32'h100, 0, 16'h0,    32'h0);
        add(0, 0, 0, 0, 0, 32'h101, 0, 16'h0,    32'h0);
        add(0, 0, 0, 0, 0, 32'h102, 1, 16'hA100, 32'h100);
        add(0, 1, 0, 0, 0, 32'h103, 1, 16'hA100, 32'h100);
        add(0, 1, 0, 0, 0, 32'h104, 1, 16'hA101, 32'h101);
        // D: redirect near the top of the index space, fetch wraps to 0.
        add(0, 1, 1, 32'hFFFF_FFFE, 1, 32'h105, 1, 16'hA102, 32'h102);
        add(0, 1, 0, 0, 0, 32'hFFFF_FFFE, 0, 16'h0, 32'h0);
        add(0, 1, 0, 0, 0, 32'hFFFF_FFFF, 0, 16'h0, 32'h0);
        add(0, 1, 0, 0, 0, 32'h0, 1, 16'h9FFE, 32'hFFFF_FFFE);
        add(0, 1, 0, 0, 0, 32'h1, 1, 16'h9FFF, 32'hFFFF_FFFF);
        add(0, 1, 0, 0, 0, 32'h2, 1, 16'hA000, 32'h0);
        add(0, 1, 0, 0, 0, 32'h3, 1, 16'hA001, 32'h1);
        // E: back-to-back redirects, the second one wins.
        add(0, 1, 1, 32'h10, 1, 32'h4,  1, 16'hA002, 32'h2);
        add(0, 1, 1, 32'h20, 1, 32'h10, 0, 16'h0,    32'h0);
        add(0, 1, 0, 0, 0, 32'h20, 0, 16'h0,    32'h0);
        add(0, 1, 0, 0, 0, 32'h21, 0, 16'h0,    32'h0);
        add(0, 1, 0, 0, 0, 32'h22, 1, 16'hA020, 32'h20);
        add(0, 1, 0, 0, 0, 32'h23, 1, 16'hA021, 32'h21);
        // F: reset in mid-stream, fetch restarts at RESET_INDEX.
        add_rst(1);
        add(0, 1, 0, 0, 1, 32'h0, 0, 16'h0,    32'h0);
        add(0, 1, 0, 0, 0, 32'h0, 0, 16'h0,    32'h0);

        @(posedge clock);
        #1;
        foreach (vecs[i]) begin
            not_reset      = ~vecs[i].rst;
            instr_ready    = vecs[i].ready;
            redirect       = vecs[i].redir;
            redirect_index = vecs[i].ridx;
            #1;
            checks++;
            if (icache_not_enable !== vecs[i].nen || icache_index !== vecs[i].idx ||
                instr_valid !== vecs[i].valid || instr !== vecs[i].ins ||
                instr_index !== vecs[i].iidx) begin
                errors++;
                $display("FAIL vec%0d: got nen=%b idx=%h valid=%b instr=%h iidx=%h, required nen=%b idx=%h valid=%b instr=%h iidx=%h",
                         i, icache_not_enable, icache_index, instr_valid, instr, instr_index,
                         vecs[i].nen, vecs[i].idx, vecs[i].valid, vecs[i].ins, vecs[i].iidx);
            end
            @(posedge clock);
            #1;
        end

        // Continued streaming after the restart: in-order indices, matching data, one per cycle.
        redirect    = 1'b0;
        instr_ready = 1'b1;
        exp_next    = 32'h0;
        pops        = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (instr_valid) begin
                checks++;
                if (instr_index !== exp_next || instr !== 16'hA000 + exp_next[15:0]) begin
                    errors++;
                    $display("FAIL stream%0d: got instr=%h iidx=%h, required instr=%h iidx=%h",
                             c, instr, instr_index, 16'hA000 + exp_next[15:0], exp_next);
                end
                exp_next = exp_next + 32'h1;
                pops++;
            end
            @(posedge clock);
            #1;
        end
        checks++;
        if (pops != 19) begin
            errors++;
            $display("FAIL throughput: got %0d pops in 20 cycles, required 19", pops);
        end

        // Asynchronous reset taking effect away from any clock edge.
        #2;
        not_reset = 1'b0;
        #1;
        checks++;
        if (icache_not_enable !== 1'b1 || instr_valid !== 1'b0 || instr !== 16'h0 ||
            instr_index !== 32'h0 || icache_index !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got nen=%b valid=%b instr=%h iidx=%h idx=%h, required nen=1 valid=0 instr=0 iidx=0 idx=0",
                     icache_not_enable, instr_valid, instr, instr_index, icache_index);
        end
        @(posedge clock);
        #1;
        not_reset = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
